// File: rtl/vx_slot_picker_pkg.sv
// Shared sizing helpers for the slot picker.
// log2up keeps index fields at least one bit wide so a single-slot pool still has an index.
package vx_slot_picker_pkg;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/VX_find_first.sv
// Priority select of the payload of the first set valid bit; scan from index 0 or from N-1.
// Purely combinational; valid_out is the OR of all valid bits.
module VX_find_first #(
    parameter int N       = 4,
    parameter int DATAW   = 8,
    parameter int REVERSE = 0
) (
    input  logic [N-1:0]       valid_in,
    input  logic [N*DATAW-1:0] data_in,
    output logic [DATAW-1:0]   data_out,
    output logic               valid_out
);

    // Later loop iterations override earlier ones, so the scan runs towards the winning end.
    always_comb begin
        data_out  = '0;
        valid_out = |valid_in;
        for (int i = 0; i < N; i++) begin
            if (REVERSE != 0) begin
                if (valid_in[i]) begin
                    data_out = data_in[i*DATAW +: DATAW];
                end
            end else begin
                if (valid_in[N-1-i]) begin
                    data_out = data_in[(N-1-i)*DATAW +: DATAW];
                end
            end
        end
    end

endmodule

// File: rtl/vx_slot_picker.sv
// Unordered N-slot pool: pushes fill the lowest free slot, the output register pulls the first/last occupied slot.
// Entry reaches out_valid one edge after its push at the earliest; out_valid & ~out_ready holds the output and frees nothing.
module vx_slot_picker
    import vx_slot_picker_pkg::*;
#(
    parameter int N       = 4,
    parameter int DATAW   = 32,
    parameter int REVERSE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATAW-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATAW-1:0]      out_data,
    output logic [log2up(N)-1:0]  out_slot,
    input  logic                  out_ready,
    output logic [$clog2(N+1):0]  occupancy
);

    localparam int LW = log2up(N);
    localparam int OW = $clog2(N+1) + 1;
    localparam int SW = LW + DATAW;

    logic [N-1:0]     slot_valid_q, slot_valid_d;
    logic [DATAW-1:0] slot_data_q [N];
    logic [DATAW-1:0] slot_data_d [N];
    logic             out_valid_q, out_valid_d;
    logic [DATAW-1:0] out_data_q, out_data_d;
    logic [LW-1:0]    out_slot_q, out_slot_d;

    logic [N*LW-1:0]  free_flat;
    logic [N*SW-1:0]  sel_flat;
    logic [LW-1:0]    free_idx;
    logic             free_any;
    logic [SW-1:0]    sel_dat;
    logic             sel_any;
    logic [LW-1:0]    sel_idx;
    logic             push;
    logic             load;

    // Each candidate carries its own slot index so the winner reports where it came from.
    always_comb begin
        free_flat = '0;
        sel_flat  = '0;
        for (int i = 0; i < N; i++) begin
            free_flat[i*LW +: LW] = LW'(i);
            sel_flat[i*SW +: SW]  = {LW'(i), slot_data_q[i]};
        end
    end

    VX_find_first #(
        .N       (N),
        .DATAW   (LW),
        .REVERSE (0)
    ) u_free_find (
        .valid_in  (~slot_valid_q),
        .data_in   (free_flat),
        .data_out  (free_idx),
        .valid_out (free_any)
    );

    VX_find_first #(
        .N       (N),
        .DATAW   (SW),
        .REVERSE (REVERSE)
    ) u_sel_find (
        .valid_in  (slot_valid_q),
        .data_in   (sel_flat),
        .data_out  (sel_dat),
        .valid_out (sel_any)
    );

    // A slot freed by this cycle's load is not visible as free until the next cycle.
    assign in_ready = free_any;
    assign push     = in_valid & free_any;
    assign load     = sel_any & (~out_valid_q | out_ready);
    assign sel_idx  = sel_dat[SW-1 -: LW];

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_slot_d   = out_slot_q;
        if (load) begin
            out_valid_d           = 1'b1;
            out_data_d            = sel_dat[DATAW-1:0];
            out_slot_d            = sel_idx;
            slot_valid_d[sel_idx] = 1'b0;
        end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
        end
        if (push) begin
            slot_valid_d[free_idx] = 1'b1;
            slot_data_d[free_idx]  = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_slot_q   <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_slot_q   <= out_slot_d;
        end
    end

    // Payload storage needs no reset: a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        slot_data_q <= slot_data_d;
    end

    always_comb begin
        occupancy = OW'(out_valid_q);
        for (int i = 0; i < N; i++) begin
            occupancy = occupancy + OW'(slot_valid_q[i]);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_slot  = out_slot_q;

endmodule

// File: tb/tb_vx_slot_picker.sv
// Bench for vx_slot_picker: a REVERSE=0 and a REVERSE=1 instance share stimulus and are
// compared against a pool model (list of occupied slots plus an output holding register).
module tb_vx_slot_picker;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [DW-1:0] out_data0, out_data1;
    logic [1:0]    out_slot0, out_slot1;
    logic [3:0]    occ0, occ1;
    logic [39:0]   obs0, obs1;

    int n_pass = 0;
    int n_chk  = 0;

    vx_slot_picker #(.N(N), .DATAW(DW), .REVERSE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_slot(out_slot0), .out_ready(out_ready), .occupancy(occ0)
    );

    vx_slot_picker #(.N(N), .DATAW(DW), .REVERSE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_slot(out_slot1), .out_ready(out_ready), .occupancy(occ1)
    );

    assign obs0 = {in_ready0, out_valid0, out_slot0, out_data0, occ0};
    assign obs1 = {in_ready1, out_valid1, out_slot1, out_data1, occ1};

    always #5 clk = ~clk;

    // Model state, index 0 = lowest-first picker, 1 = highest-first picker.
    logic          m_sv [2][N];
    logic [DW-1:0] m_sd [2][N];
    logic          m_ov [2];
    logic [DW-1:0] m_od [2];
    int            m_os [2];

    function automatic void model_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) m_sv[r][i] = 1'b0;
            m_ov[r] = 1'b0;
            m_od[r] = '0;
            m_os[r] = 0;
        end
    endfunction

    function automatic void model_step(input logic iv, input logic [DW-1:0] id, input logic ordy);
        for (int r = 0; r < 2; r++) begin
            int occ_list[$];
            int free_list[$];
            int s;
            for (int i = 0; i < N; i++) begin
                if (m_sv[r][i]) occ_list.push_back(i);
                else            free_list.push_back(i);
            end
            if (occ_list.size() > 0 && (!m_ov[r] || ordy)) begin
                s = (r == 0) ? occ_list[0] : occ_list[occ_list.size()-1];
                m_od[r]    = m_sd[r][s];
                m_os[r]    = s;
                m_ov[r]    = 1'b1;
                m_sv[r][s] = 1'b0;
            end else if (occ_list.size() == 0 && ordy) begin
                m_ov[r] = 1'b0;
            end
            if (iv && free_list.size() > 0) begin
                m_sv[r][free_list[0]] = 1'b1;
                m_sd[r][free_list[0]] = id;
            end
        end
    endfunction

    function automatic logic [39:0] exp_obs(input int r);
        int   cnt;
        logic rdy;
        cnt = m_ov[r] ? 1 : 0;
        rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_sv[r][i]) cnt++;
            else            rdy = 1'b1;
        end
        return {rdy, m_ov[r], 2'(m_os[r]), m_od[r], 4'(cnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(in_valid, in_data, out_ready);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_chk++; if (obs0 !== {1'b1, 1'b0, 2'd0, 32'd0, 4'd0}) $display("FAIL reset_state0 got=%h exp=%h", obs0, {1'b1, 1'b0, 2'd0, 32'd0, 4'd0}); else n_pass++;
        n_chk++; if (obs1 !== {1'b1, 1'b0, 2'd0, 32'd0, 4'd0}) $display("FAIL reset_state1 got=%h exp=%h", obs1, {1'b1, 1'b0, 2'd0, 32'd0, 4'd0}); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k + 1);
            tick();
        end
        in_valid = 1'b0;
        n_chk++; if (occ0 !== 4'd3) $display("FAIL pre_reset_occ got=%0d exp=3", occ0); else n_pass++;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_chk++; if ({out_valid0, occ0, in_ready0} !== {1'b0, 4'd0, 1'b1}) $display("FAIL midreset0 got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", out_valid0, occ0, in_ready0); else n_pass++;
        n_chk++; if ({out_valid1, occ1, in_ready1} !== {1'b0, 4'd0, 1'b1}) $display("FAIL midreset1 got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", out_valid1, occ1, in_ready1); else n_pass++;
        @(negedge clk);
        reset_n   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hA5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_valid0 !== 1'b0) $display("FAIL a5_no_bypass got v=%b exp 0", out_valid0); else n_pass++;
        tick();
        n_chk++; if ({out_valid0, out_data0, out_slot0} !== {1'b1, 32'hA5, 2'd0}) $display("FAIL a5_out got v=%b d=%h s=%0d exp v=1 d=a5 s=0", out_valid0, out_data0, out_slot0); else n_pass++;
        n_chk++; if (obs1 !== exp_obs(1)) $display("FAIL a5_model1 got=%h exp=%h", obs1, exp_obs(1)); else n_pass++;
    endtask

    task automatic test_fill_stall();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h11 * (k + 1));
            tick();
            n_chk++; if (obs0 !== exp_obs(0)) $display("FAIL fill%0d_0 got=%h exp=%h", k, obs0, exp_obs(0)); else n_pass++;
            n_chk++; if (obs1 !== exp_obs(1)) $display("FAIL fill%0d_1 got=%h exp=%h", k, obs1, exp_obs(1)); else n_pass++;
            if (k >= 1) begin
                n_chk++; if ({out_data0, out_slot0} !== {32'h11, 2'd0}) $display("FAIL stall_hold%0d got d=%h s=%0d exp d=11 s=0", k, out_data0, out_slot0); else n_pass++;
            end
        end
        in_valid = 1'b0;
        n_chk++; if ({in_ready0, occ0} !== {1'b0, 4'd5}) $display("FAIL full got rdy=%b occ=%0d exp rdy=0 occ=5", in_ready0, occ0); else n_pass++;
    endtask

    task automatic test_full_pop();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h66;
        #1;
        n_chk++; if (in_ready0 !== 1'b0) $display("FAIL pop_cycle_rdy got=%b exp=0", in_ready0); else n_pass++;
        tick();
        out_ready = 1'b0;
        in_data   = 32'h77;
        n_chk++; if ({in_ready0, in_ready1} !== 2'b11) $display("FAIL after_pop_rdy got=%b exp=11", {in_ready0, in_ready1}); else n_pass++;
        n_chk++; if (obs0 !== exp_obs(0)) $display("FAIL after_pop0 got=%h exp=%h", obs0, exp_obs(0)); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_chk++; if ({in_ready0, occ0} !== {1'b0, 4'd5}) $display("FAIL refill got rdy=%b occ=%0d exp rdy=0 occ=5", in_ready0, occ0); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_chk++; if (obs0 !== exp_obs(0)) $display("FAIL popdrain%0d_0 got=%h exp=%h", k, obs0, exp_obs(0)); else n_pass++;
            n_chk++; if (obs1 !== exp_obs(1)) $display("FAIL popdrain%0d_1 got=%h exp=%h", k, obs1, exp_obs(1)); else n_pass++;
        end
    endtask

    task automatic test_drain_order();
        logic [DW-1:0] e0 [5];
        logic [DW-1:0] e1 [5];
        logic [1:0]    s0 [5];
        logic [1:0]    s1 [5];
        e0 = '{32'hEE, 32'hA, 32'hB, 32'hC, 32'hD};
        e1 = '{32'hEE, 32'hD, 32'hC, 32'hB, 32'hA};
        s0 = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        s1 = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'hEE;
        tick();
        in_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'hA + k);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            n_chk++; if ({out_valid0, out_data0, out_slot0} !== {1'b1, e0[j], s0[j]}) $display("FAIL drain_fwd%0d got v=%b d=%h s=%0d exp d=%h s=%0d", j, out_valid0, out_data0, out_slot0, e0[j], s0[j]); else n_pass++;
            n_chk++; if ({out_valid1, out_data1, out_slot1} !== {1'b1, e1[j], s1[j]}) $display("FAIL drain_rev%0d got v=%b d=%h s=%0d exp d=%h s=%0d", j, out_valid1, out_data1, out_slot1, e1[j], s1[j]); else n_pass++;
            tick();
        end
        n_chk++; if ({out_valid0, out_valid1, occ0, occ1} !== {2'b00, 4'd0, 4'd0}) $display("FAIL drain_empty got v=%b%b occ=%0d/%0d exp v=00 occ=0/0", out_valid0, out_valid1, occ0, occ1); else n_pass++;
    endtask

    task automatic test_streaming();
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            in_data = 32'(e - 1);
            tick();
            if (e >= 2) begin
                n_chk++; if ({out_valid0, out_data0} !== {1'b1, 32'(e - 2)}) $display("FAIL stream%0d got v=%b d=%0d exp v=1 d=%0d", e, out_valid0, out_data0, e - 2); else n_pass++;
            end
            n_chk++; if (occ0 > 4'd2) $display("FAIL stream_occ%0d got=%0d exp<=2", e, occ0); else n_pass++;
        end
        in_valid = 1'b0;
        n_chk++; if (obs1 !== exp_obs(1)) $display("FAIL stream_model1 got=%h exp=%h", obs1, exp_obs(1)); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                n_chk++; if (obs0 !== exp_obs(0)) $display("FAIL rnd_reset0 got=%h exp=%h", obs0, exp_obs(0)); else n_pass++;
                @(negedge clk);
                reset_n = 1'b1;
            end
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = $urandom();
            out_ready = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 40 : 80));
            tick();
            n_chk++; if (obs0 !== exp_obs(0)) $display("FAIL rnd%0d_0 got=%h exp=%h", c, obs0, exp_obs(0)); else n_pass++;
            n_chk++; if (obs1 !== exp_obs(1)) $display("FAIL rnd%0d_1 got=%h exp=%h", c, obs1, exp_obs(1)); else n_pass++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_full_pop();
        test_drain_order();
        test_streaming();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
